// File: rtl/insn_queue.sv
// ============================================================================
//  Module   : insn_queue
//  Purpose  : Decoupling instruction queue between the IF and ID stages.
//             Circular buffer of DEPTH {PC, Insn} entries; back-pressures IF
//             with IFStall when full and discards everything on Flush.
//  Options  : `define INSN_QUEUE_BYPASS_EN for a zero-latency IF -> ID
//             bypass while the queue is empty (default: 1-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_queue #(
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic [WORD_ADDR_W-1:0] IFPC,
  input  logic [WORD_DATA_W-1:0] IFInsn,
  input  logic                   IFEn,
  output logic                   IFStall,
  input  logic                   Flush,
  input  logic                   IDStall,
  output logic [WORD_ADDR_W-1:0] QPC,
  output logic [WORD_DATA_W-1:0] QInsn,
  output logic                   QEn,
  output logic [PTR_W:0]         QCount
);

  localparam logic [PTR_W:0]   c_full_cnt = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

  // Storage and pointer state
  logic [WORD_ADDR_W-1:0] pc_q   [DEPTH];
  logic [WORD_DATA_W-1:0] insn_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_qen;

  // Full/empty come only from the registered count, so IFStall never sees ID
  assign w_full  = (count_q == c_full_cnt);
  assign w_empty = (count_q == '0);
  assign IFStall = w_full;
  assign QCount  = count_q;

`ifdef INSN_QUEUE_BYPASS_EN
  logic w_bypass;

  // Empty queue: IF entry goes straight to ID; it is stored only if ID stalls
  always_comb begin
    w_bypass = w_empty & IFEn & ~Flush & ~IDStall;
    w_qen    = w_empty ? (IFEn & ~Flush) : 1'b1;
    w_push   = IFEn & ~w_full & ~Flush & ~w_bypass;
    w_pop    = ~w_empty & ~IDStall & ~Flush;
    if (!w_qen) begin
      QPC   = '0;
      QInsn = '0;
    end else if (w_empty) begin
      QPC   = IFPC;
      QInsn = IFInsn;
    end else begin
      QPC   = pc_q[rd_ptr_q];
      QInsn = insn_q[rd_ptr_q];
    end
  end
`else
  // Head is always served from storage; an empty queue presents a NOP (0)
  always_comb begin
    w_qen  = ~w_empty;
    w_push = IFEn & ~w_full & ~Flush;
    w_pop  = w_qen & ~IDStall & ~Flush;
    if (w_qen) begin
      QPC   = pc_q[rd_ptr_q];
      QInsn = insn_q[rd_ptr_q];
    end else begin
      QPC   = '0;
      QInsn = '0;
    end
  end
`endif

  assign QEn = w_qen;

  // Next pointer/count; flush wins over any push or pop in the same cycle
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
      else if (w_pop && !w_push) count_d = count_q - c_cnt_one;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written at wr_ptr on every accepted push
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        insn_q[i] <= '0;
      end
    end else if (w_push) begin
      pc_q[wr_ptr_q]   <= IFPC;
      insn_q[wr_ptr_q] <= IFInsn;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_insn_queue.sv
// ============================================================================
//  Module   : tb_insn_queue
//  Purpose  : Directed self-checking bench for insn_queue (default build,
//             no bypass): reset, latency, full/back-pressure, wrap, flush,
//             asynchronous reset and refused-push-while-popping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insn_queue;

  logic        clk;
  logic        reset_;
  logic [29:0] IFPC;
  logic [31:0] IFInsn;
  logic        IFEn;
  logic        IFStall;
  logic        Flush;
  logic        IDStall;
  logic [29:0] QPC;
  logic [31:0] QInsn;
  logic        QEn;
  logic [2:0]  QCount;

  int n_checks;
  int n_errors;

  insn_queue #(
    .DEPTH(4),
    .PTR_W(2),
    .WORD_ADDR_W(30),
    .WORD_DATA_W(32)
  ) u_dut (
    .clk     (clk),
    .reset_  (reset_),
    .IFPC    (IFPC),
    .IFInsn  (IFInsn),
    .IFEn    (IFEn),
    .IFStall (IFStall),
    .Flush   (Flush),
    .IDStall (IDStall),
    .QPC     (QPC),
    .QInsn   (QInsn),
    .QEn     (QEn),
    .QCount  (QCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic en, input logic [29:0] pc, input logic [31:0] insn);
    IFEn   = en;
    IFPC   = pc;
    IFInsn = insn;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_  = 1'b0;
    IFEn    = 1'b0;
    IFPC    = '0;
    IFInsn  = '0;
    Flush   = 1'b0;
    IDStall = 1'b0;

    // Reset state
    #2;
    chk("rst_qen",     QEn,     0);
    chk("rst_qpc",     QPC,     0);
    chk("rst_qinsn",   QInsn,   0);
    chk("rst_qcount",  QCount,  0);
    chk("rst_ifstall", IFStall, 0);
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    tick();

    // One-cycle latency IF -> ID
    present(1'b1, 30'h10, 32'h12345678);
    chk("lat_qen_before", QEn, 0);
    tick();
    present(1'b0, 30'h3FF, 32'hDEADBEEF);
    chk("lat_qen",    QEn,    1);
    chk("lat_qpc",    QPC,    30'h10);
    chk("lat_qinsn",  QInsn,  32'h12345678);
    chk("lat_qcount", QCount, 1);
    tick();
    chk("lat_drain_qen",   QEn,    0);
    chk("lat_drain_count", QCount, 0);
    chk("lat_drain_qpc",   QPC,    0);

    // Fill to full while ID stalls
    IDStall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      present(1'b1, 30'(i), 32'(32'h100 + i));
      tick();
    end
    chk("full_count",   QCount,  4);
    chk("full_ifstall", IFStall, 1);
    chk("full_head",    QPC,     1);
    present(1'b1, 30'h5, 32'h105);
    tick();
    chk("refuse_count",   QCount,  4);
    chk("refuse_ifstall", IFStall, 1);
    chk("refuse_head",    QPC,     1);

    // Release ID while full: pop happens, push of 0x5 is refused this edge
    IDStall = 1'b0;
    tick();
    chk("popfull_count",   QCount,  3);
    chk("popfull_head",    QPC,     2);
    chk("popfull_ifstall", IFStall, 0);
    tick();   // IF re-presents 0x5, accepted now
    present(1'b0, 30'h0, 32'h0);
    chk("repush_count", QCount, 3);
    chk("seq_3",        QPC,    3);
    tick();
    chk("seq_4",       QPC,    4);
    chk("seq_4_count", QCount, 2);
    tick();
    chk("seq_5",       QPC,    5);
    chk("seq_5_insn",  QInsn,  32'h105);
    chk("seq_5_count", QCount, 1);
    tick();
    chk("seq_end_qen",   QEn,    0);
    chk("seq_end_count", QCount, 0);

    // Steady state at occupancy 2, push and pop together across wraps
    IDStall = 1'b1;
    present(1'b1, 30'h20, 32'hA020);
    tick();
    present(1'b1, 30'h21, 32'hA021);
    tick();
    chk("steady_count0", QCount, 2);
    IDStall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      present(1'b1, 30'(30'h22 + k), 32'(32'hA022 + k));
      tick();
      chk("steady_count", QCount, 2);
      chk("steady_head",  QPC,    30'(30'h21 + k));
      chk("steady_insn",  QInsn,  32'(32'hA021 + k));
    end

    // IFEn=0 never pushes, whatever PC/Insn hold
    IDStall = 1'b1;
    present(1'b0, 30'h3AA, 32'hFFFFFFFF);
    tick();
    chk("noen_count", QCount, 2);
    chk("noen_head",  QPC,    30'h2A);

    // Flush at occupancy 3 with IFEn=1 drops everything, incoming included
    present(1'b1, 30'h30, 32'hA030);
    tick();
    chk("preflush_count", QCount, 3);
    Flush = 1'b1;
    present(1'b1, 30'h31, 32'hA031);
    tick();
    Flush = 1'b0;
    present(1'b0, 30'h0, 32'h0);
    chk("flush_qen",    QEn,    0);
    chk("flush_count",  QCount, 0);
    chk("flush_qpc",    QPC,    0);
    chk("flush_qinsn",  QInsn,  0);
    present(1'b1, 30'h40, 32'hA040);
    tick();
    present(1'b0, 30'h0, 32'h0);
    chk("postflush_qen",   QEn,    1);
    chk("postflush_head",  QPC,    30'h40);
    chk("postflush_insn",  QInsn,  32'hA040);
    chk("postflush_count", QCount, 1);

    // Asynchronous reset mid-stream at occupancy 3
    present(1'b1, 30'h50, 32'hA050);
    tick();
    present(1'b1, 30'h51, 32'hA051);
    tick();
    present(1'b0, 30'h0, 32'h0);
    chk("prerst_count", QCount, 3);
    #2;
    reset_ = 1'b0;
    #1;
    chk("arst_qen",     QEn,     0);
    chk("arst_ifstall", IFStall, 0);
    chk("arst_count",   QCount,  0);
    chk("arst_qpc",     QPC,     0);
    @(negedge clk);
    reset_ = 1'b1;
    tick();
    chk("arst_after_count", QCount, 0);
    chk("arst_after_qen",   QEn,    0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
